mandel_view_ctrl: RTL

MANDEL_VIEW_CTRL -- requirements
Module: mandel_view_ctrl

---
 rtl/mandel_view_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mandel_view_ctrl.sv
// View controller for a Mandelbrot renderer: turns button pulses into committed
// view parameters (origin, step, iteration limit) and sequences one render per change.
module mandel_view_ctrl #(
    parameter int                  FP_WIDTH = 25,
    parameter logic [FP_WIDTH-1:0] X_START  = 25'h1900000,
    parameter logic [FP_WIDTH-1:0] Y_START  = 25'h1D00000,
    parameter logic [FP_WIDTH-1:0] STEP     = 25'h0008000,
    parameter int                  ITER_LO  = 128,
    parameter int                  ITER_HI  = 255,
    parameter int                  ITER_INC = 32,
    parameter int                  ITERW    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sig_mode,
    input  logic                sig_up,
    input  logic                sig_dn,
    input  logic                sig_left,
    input  logic                sig_right,
    input  logic                sig_home,
    input  logic                render_done,
    output logic                start,
    output logic [FP_WIDTH-1:0] x_start,
    output logic [FP_WIDTH-1:0] y_start,
    output logic [FP_WIDTH-1:0] step,
    output logic [ITERW-1:0]    iter_lim,
    output logic [1:0]          mode,
    output logic                busy,
    output logic                cmd_pend
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CALC, ST_CHECK, ST_COMMIT, ST_START, ST_WAIT
    } state_t;

    typedef enum logic [2:0] {
        CMD_HOME, CMD_LEFT, CMD_RIGHT, CMD_UP, CMD_DN
    } cmd_t;

    localparam logic [1:0] MODE_MOVE = 2'd0;
    localparam logic [1:0] MODE_ZOOM = 2'd1;
    localparam logic [1:0] MODE_ITER = 2'd2;

    localparam logic [ITERW:0]   INC_W = (ITERW+1)'(ITER_INC);
    localparam logic [ITERW:0]   HI_W  = (ITERW+1)'(ITER_HI);
    localparam logic [ITERW:0]   LO_W  = (ITERW+1)'(ITER_LO);
    localparam logic [ITERW-1:0] HI_N  = ITERW'(ITER_HI);
    localparam logic [ITERW-1:0] LO_N  = ITERW'(ITER_LO);

    state_t              state_reg;
    logic [1:0]          mode_reg;
    logic                slot_full_reg;
    cmd_t                slot_cmd_reg;
    logic [1:0]          slot_mode_reg;
    logic [FP_WIDTH-1:0] x_reg, y_reg, step_reg;
    logic [ITERW-1:0]    iter_reg;
    logic [FP_WIDTH-1:0] xc_reg, yc_reg, sc_reg;
    logic [ITERW-1:0]    ic_reg;

    logic                cap_valid;
    cmd_t                cap_cmd;
    logic [FP_WIDTH-1:0] xc_next, yc_next, sc_next;
    logic [ITERW-1:0]    ic_next;
    logic [ITERW:0]      iter_sum;
    logic                reject;

    always_comb begin
        cap_valid = sig_home | sig_left | sig_right | sig_up | sig_dn;
        cap_cmd   = CMD_DN;
        if (sig_home)       cap_cmd = CMD_HOME;
        else if (sig_left)  cap_cmd = CMD_LEFT;
        else if (sig_right) cap_cmd = CMD_RIGHT;
        else if (sig_up)    cap_cmd = CMD_UP;
    end

    // Candidates always start from the committed view; only the slot's command edits them.
    always_comb begin
        xc_next  = x_reg;
        yc_next  = y_reg;
        sc_next  = step_reg;
        ic_next  = iter_reg;
        iter_sum = {1'b0, iter_reg} + INC_W;
        if (slot_cmd_reg == CMD_HOME) begin
            xc_next = X_START;
            yc_next = Y_START;
            sc_next = STEP;
            ic_next = HI_N;
        end else begin
            case (slot_mode_reg)
                MODE_MOVE: begin
                    case (slot_cmd_reg)
                        CMD_LEFT:  xc_next = x_reg - (step_reg << 4);
                        CMD_RIGHT: xc_next = x_reg + (step_reg << 4);
                        CMD_UP:    yc_next = y_reg - (step_reg << 4);
                        CMD_DN:    yc_next = y_reg + (step_reg << 4);
                        default: ;
                    endcase
                end
                MODE_ZOOM: begin
                    if (slot_cmd_reg == CMD_UP) begin
                        xc_next = x_reg - (step_reg << 7);
                        yc_next = y_reg - (step_reg << 6) - (step_reg << 5);
                        sc_next = step_reg << 1;
                    end else if (slot_cmd_reg == CMD_DN) begin
                        xc_next = x_reg + (step_reg << 6);
                        yc_next = y_reg + (step_reg << 5) + (step_reg << 4);
                        sc_next = step_reg >> 1;
                    end
                end
                MODE_ITER: begin
                    if (slot_cmd_reg == CMD_UP) begin
                        ic_next = (iter_sum > HI_W) ? HI_N : iter_sum[ITERW-1:0];
                    end else if (slot_cmd_reg == CMD_DN) begin
                        ic_next = ({1'b0, iter_reg} < (LO_W + INC_W)) ? LO_N
                                                                      : iter_reg - INC_W[ITERW-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign reject = (sc_reg == '0) || (sc_reg > STEP) ||
                    (xc_reg == x_reg && yc_reg == y_reg && sc_reg == step_reg && ic_reg == iter_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_START;
            mode_reg      <= MODE_MOVE;
            slot_full_reg <= 1'b0;
            slot_cmd_reg  <= CMD_HOME;
            slot_mode_reg <= MODE_MOVE;
            x_reg         <= X_START;
            y_reg         <= Y_START;
            step_reg      <= STEP;
            iter_reg      <= HI_N;
            xc_reg        <= X_START;
            yc_reg        <= Y_START;
            sc_reg        <= STEP;
            ic_reg        <= HI_N;
        end else begin
            if (sig_mode)
                mode_reg <= (mode_reg == MODE_ITER) ? MODE_MOVE : mode_reg + 2'd1;

            // The CALC cycle empties the slot, so it may refill in that same cycle.
            if ((state_reg == ST_CALC || !slot_full_reg) && cap_valid) begin
                slot_full_reg <= 1'b1;
                slot_cmd_reg  <= cap_cmd;
                slot_mode_reg <= mode_reg;
            end else if (state_reg == ST_CALC) begin
                slot_full_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE:   if (slot_full_reg || cap_valid) state_reg <= ST_CALC;
                ST_CALC: begin
                    xc_reg    <= xc_next;
                    yc_reg    <= yc_next;
                    sc_reg    <= sc_next;
                    ic_reg    <= ic_next;
                    state_reg <= ST_CHECK;
                end
                ST_CHECK:  state_reg <= reject ? ST_IDLE : ST_COMMIT;
                ST_COMMIT: begin
                    x_reg     <= xc_reg;
                    y_reg     <= yc_reg;
                    step_reg  <= sc_reg;
                    iter_reg  <= ic_reg;
                    state_reg <= ST_START;
                end
                ST_START:  state_reg <= ST_WAIT;
                ST_WAIT:   if (render_done) state_reg <= ST_IDLE;
                default:   state_reg <= ST_IDLE;
            endcase
        end
    end

    // Gated by rst so the START state held during reset does not fire a render.
    assign start    = (state_reg == ST_START) && !rst;
    assign busy     = (state_reg != ST_IDLE);
    assign cmd_pend = slot_full_reg;
    assign mode     = mode_reg;
    assign x_start  = x_reg;
    assign y_start  = y_reg;
    assign step     = step_reg;
    assign iter_lim = iter_reg;

endmodule
